sync_ctrl: RTL

Acquisition and tracking controller for the CP timing-synchronisation chain. It consumes the per-window argmax results (`theta_in`/`argmax_valid`) produced from the λ stream, and confirms a stable symbol timing over several windows before declaring lock. While locked it tracks that timing and drops back to acquisition after repeated misses. It also restarts the argmax datapath on (re)acquisition, and emits a per-symbol start strobe aligned to the locked timing index.

---
 rtl/sync_ctrl_if.sv | 23 ++
 rtl/sync_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sync_ctrl_if.sv
// Handshake bundle between the argmax datapath and the timing-sync controller.
// master drives the enable, sample and argmax strobes; slave is the controller.
interface sync_ctrl_if;
    logic       sync_en;
    logic       sample_valid;
    logic       argmax_valid;
    logic [7:0] theta_in;
    logic       argmax_clr;
    logic       locked;
    logic [7:0] theta_lock;
    logic       sym_start;
    logic [1:0] state_o;

    modport master (
        output sync_en, sample_valid, argmax_valid, theta_in,
        input  argmax_clr, locked, theta_lock, sym_start, state_o
    );

    modport slave (
        input  sync_en, sample_valid, argmax_valid, theta_in,
        output argmax_clr, locked, theta_lock, sym_start, state_o
    );
endinterface

// File: rtl/sync_ctrl.sv
// CP timing acquisition/tracking controller: confirms a stable argmax index, tracks it
// while locked, restarts the argmax datapath on (re)acquisition and emits symbol strobes.
module sync_ctrl #(
    parameter int unsigned N        = 256,
    parameter int unsigned L        = 16,
    parameter int unsigned CONFIRM  = 3,
    parameter int unsigned TOL      = 2,
    parameter int unsigned MISS_MAX = 2
) (
    input logic       clk,
    input logic       rst,
    sync_ctrl_if.slave bus
);
    localparam int unsigned WuW    = $clog2(N + L);
    localparam int unsigned PosW   = $clog2(N);
    localparam int unsigned MatchW = $clog2(CONFIRM + 1);
    localparam int unsigned MissW  = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAcq    = 2'd1,
        StVerify = 2'd2,
        StLocked = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        theta_ref_q, theta_ref_d;
    logic [7:0]        theta_lock_q, theta_lock_d;
    logic [MatchW-1:0] match_cnt_q, match_cnt_d;
    logic [MissW-1:0]  miss_cnt_q, miss_cnt_d;
    logic              clr_q, clr_d;
    logic [WuW-1:0]    wu_cnt_q, wu_cnt_d;
    logic [PosW-1:0]   wpos_q, wpos_d;
    logic              wu_done_q, wu_done_d;
    logic              sym_start_q, sym_start_d;

    logic [7:0] ref_sel;
    logic [7:0] diff;
    logic       is_match;

    // In LOCKED the reference is the tracked index, otherwise the candidate under test.
    always_comb begin
        ref_sel  = (state_q == StLocked) ? theta_lock_q : theta_ref_q;
        diff     = bus.theta_in - ref_sel;
        is_match = (32'(diff) <= TOL) || (32'(diff) >= N - TOL);
    end

    // Sample position counters shadow the argmax datapath's own warm-up and window.
    always_comb begin
        wu_cnt_d    = wu_cnt_q;
        wpos_d      = wpos_q;
        wu_done_d   = wu_done_q;
        sym_start_d = (state_q == StLocked) && wu_done_q && bus.sample_valid &&
                      (32'(wpos_q) == 32'(theta_lock_q));
        if (clr_q) begin
            wu_cnt_d  = '0;
            wpos_d    = '0;
            wu_done_d = 1'b0;
        end else if (bus.sample_valid) begin
            if (!wu_done_q) begin
                if (32'(wu_cnt_q) == N + L - 1) wu_done_d = 1'b1;
                else                             wu_cnt_d  = wu_cnt_q + 1'b1;
            end else begin
                wpos_d = (32'(wpos_q) == N - 1) ? '0 : wpos_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        theta_ref_d  = theta_ref_q;
        theta_lock_d = theta_lock_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        clr_d        = 1'b0;
        if (!bus.sync_en) begin
            state_d     = StIdle;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAcq;
                    clr_d   = 1'b1;
                end
                StAcq: begin
                    if (bus.argmax_valid) begin
                        theta_ref_d = bus.theta_in;
                        match_cnt_d = MatchW'(1);
                        state_d     = StVerify;
                    end
                end
                StVerify: begin
                    if (bus.argmax_valid) begin
                        if (is_match) begin
                            match_cnt_d = match_cnt_q + 1'b1;
                            if (32'(match_cnt_q) + 32'd1 == CONFIRM) begin
                                state_d      = StLocked;
                                theta_lock_d = theta_ref_q;
                                miss_cnt_d   = '0;
                            end
                        end else begin
                            theta_ref_d = bus.theta_in;
                            match_cnt_d = MatchW'(1);
                        end
                    end
                end
                StLocked: begin
                    if (bus.argmax_valid) begin
                        if (is_match) begin
                            theta_lock_d = bus.theta_in;
                            miss_cnt_d   = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                            if (32'(miss_cnt_q) + 32'd1 == MISS_MAX) begin
                                state_d = StAcq;
                                clr_d   = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            theta_ref_q  <= '0;
            theta_lock_q <= '0;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            clr_q        <= 1'b0;
            wu_cnt_q     <= '0;
            wpos_q       <= '0;
            wu_done_q    <= 1'b0;
            sym_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            theta_ref_q  <= theta_ref_d;
            theta_lock_q <= theta_lock_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            clr_q        <= clr_d;
            wu_cnt_q     <= wu_cnt_d;
            wpos_q       <= wpos_d;
            wu_done_q    <= wu_done_d;
            sym_start_q  <= sym_start_d;
        end
    end

    assign bus.argmax_clr = clr_q;
    assign bus.locked     = (state_q == StLocked);
    assign bus.theta_lock = theta_lock_q;
    assign bus.sym_start  = sym_start_q;
    assign bus.state_o    = state_q;
endmodule
